// File: rtl/trng_vn_byte_packer_if.sv
// Handshake bundle between the raw TRNG source, the byte packer and the byte consumer.
interface trng_vn_byte_packer_if #(
  parameter int unsigned FIFO_DEPTH = 4
) ();
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic            raw_bit;
  logic            raw_valid;
  logic            clear;
  logic            out_ready;
  logic [7:0]      out_data;
  logic            out_valid;
  logic [CntW-1:0] fifo_count;
  logic            overflow;
  logic            health_fail;

  modport master (
    output raw_bit, raw_valid, clear, out_ready,
    input  out_data, out_valid, fifo_count, overflow, health_fail
  );

  modport slave (
    input  raw_bit, raw_valid, clear, out_ready,
    output out_data, out_valid, fifo_count, overflow, health_fail
  );
endinterface

// File: rtl/trng_vn_byte_packer.sv
// Von Neumann debiaser + byte packer + FWFT output FIFO for the raw TRNG stream.
// Optional repetition-count health test is built when TRNG_HEALTH_TEST_EN is defined.
module trng_vn_byte_packer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RCT_CUTOFF = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  trng_vn_byte_packer_if.slave   bus_io
);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic            pair_full_q, pair_bit_q;
  logic [7:0]      shreg_q;
  logic [2:0]      bit_cnt_q;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q;
  logic            health_fail_q;

  logic       accept, emit, byte_done, pop, full, push_req, push, drop;
  logic [7:0] new_byte;

  always_comb begin
    accept    = bus_io.raw_valid & ~bus_io.clear;
    // Second bit of a pair differing from the first: the first bit is the debiased output.
    emit      = accept & pair_full_q & (pair_bit_q ^ bus_io.raw_bit);
    byte_done = emit & (bit_cnt_q == 3'd7);
    new_byte  = {shreg_q[6:0], pair_bit_q};
    pop       = (count_q != '0) & bus_io.out_ready & ~bus_io.clear;
    full      = (count_q == CntW'(FIFO_DEPTH));
    push_req  = byte_done & ~health_fail_q;
    push      = push_req & (~full | pop);
    drop      = push_req & ~push;
    count_d   = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pair_full_q <= 1'b0;
      pair_bit_q  <= 1'b0;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (bus_io.clear) begin
      pair_full_q <= 1'b0;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      if (accept) begin
        pair_full_q <= ~pair_full_q;
        if (!pair_full_q) begin
          pair_bit_q <= bus_io.raw_bit;
        end
      end
      // Counter wraps 7->0 whether the byte is pushed, dropped or suppressed.
      if (emit) begin
        shreg_q   <= new_byte;
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end
      if (push) begin
        mem_q[wr_ptr_q] <= new_byte;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_d;
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

`ifdef TRNG_HEALTH_TEST_EN
  localparam int unsigned RctW = $clog2(RCT_CUTOFF + 1);

  logic [RctW-1:0] rct_cnt_q, rct_cnt_d;
  logic            prev_bit_q;

  always_comb begin
    rct_cnt_d = rct_cnt_q;
    if (accept) begin
      if ((rct_cnt_q != '0) && (bus_io.raw_bit == prev_bit_q)) begin
        rct_cnt_d = (rct_cnt_q == RctW'(RCT_CUTOFF)) ? rct_cnt_q : rct_cnt_q + RctW'(1);
      end else begin
        rct_cnt_d = RctW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rct_cnt_q     <= '0;
      prev_bit_q    <= 1'b0;
      health_fail_q <= 1'b0;
    end else if (bus_io.clear) begin
      rct_cnt_q     <= '0;
      health_fail_q <= 1'b0;
    end else begin
      rct_cnt_q <= rct_cnt_d;
      if (accept) begin
        prev_bit_q <= bus_io.raw_bit;
      end
      if (rct_cnt_d == RctW'(RCT_CUTOFF)) begin
        health_fail_q <= 1'b1;
      end
    end
  end
`else
  logic unused_rct_cutoff;
  assign unused_rct_cutoff = (RCT_CUTOFF != 0);
  assign health_fail_q     = 1'b0;
`endif

  assign bus_io.out_valid   = (count_q != '0);
  assign bus_io.out_data    = (count_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
  assign bus_io.fifo_count  = count_q;
  assign bus_io.overflow    = overflow_q;
  assign bus_io.health_fail = health_fail_q;

endmodule

// File: tb/tb_trng_vn_byte_packer.sv
// Directed self-checking bench for trng_vn_byte_packer (FIFO_DEPTH=4, RCT_CUTOFF=32).
module tb_trng_vn_byte_packer;
`ifdef TRNG_HEALTH_TEST_EN
  localparam bit HealthEn = 1'b1;
`else
  localparam bit HealthEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vec_cnt = 0;
  int   err_cnt = 0;
  logic [7:0] popped [$];

  trng_vn_byte_packer_if #(.FIFO_DEPTH(4)) bus ();

  trng_vn_byte_packer #(
    .FIFO_DEPTH(4),
    .RCT_CUTOFF(32)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  // Record every byte the consumer takes; pops land on the following rising edge.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready && !bus.clear) begin
      popped.push_back(bus.out_data);
    end
  end

  task automatic feed_bit(input logic b);
    bus.raw_bit   = b;
    bus.raw_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.raw_valid = 1'b0;
  endtask

  task automatic feed_pair(input logic [1:0] p);
    feed_bit(p[1]);
    feed_bit(p[0]);
  endtask

  // One byte MSB first as 10 (=1) / 01 (=0) pairs, optionally with 00/11 junk pairs,
  // optionally with a pop forced on the cycle of the final raw bit.
  task automatic feed_byte(input logic [7:0] b, input bit junk, input bit pop_last);
    logic [1:0] p;
    for (int i = 7; i >= 0; i--) begin
      if (junk) feed_pair(i[0] ? 2'b11 : 2'b00);
      p = b[i] ? 2'b10 : 2'b01;
      if (pop_last && i == 0) begin
        feed_bit(p[1]);
        bus.out_ready = 1'b1;
        feed_bit(p[0]);
        bus.out_ready = 1'b0;
      end else begin
        feed_pair(p);
      end
    end
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    @(posedge clk);
    #1;
    bus.clear = 1'b0;
  endtask

  task automatic test_reset();
    bus.raw_bit = 1'b0; bus.raw_valid = 1'b0; bus.clear = 1'b0; bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    vec_cnt++; if (bus.out_data !== 8'h00) begin err_cnt++; $display("FAIL rst_data: got %h want 00", bus.out_data); end
    vec_cnt++; if (bus.out_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_valid: got %b want 0", bus.out_valid); end
    vec_cnt++; if (bus.fifo_count !== 3'd0) begin err_cnt++; $display("FAIL rst_count: got %0d want 0", bus.fifo_count); end
    vec_cnt++; if (bus.overflow !== 1'b0) begin err_cnt++; $display("FAIL rst_ovf: got %b want 0", bus.overflow); end
    vec_cnt++; if (bus.health_fail !== 1'b0) begin err_cnt++; $display("FAIL rst_hf: got %b want 0", bus.health_fail); end
  endtask

  // Pairs 10,01,10,10,01,01,10,01 -> bits 1,0,1,1,0,0,1,0 -> 8'hB2 (first bit is MSB).
  task automatic test_single_byte(input bit junk);
    popped.delete();
    bus.out_ready = 1'b1;
    feed_byte(8'hB2, junk, 1'b0);
    vec_cnt++; if (bus.out_valid !== 1'b1) begin err_cnt++; $display("FAIL single_valid(j=%0d): got %b want 1", junk, bus.out_valid); end
    vec_cnt++; if (bus.out_data !== 8'hB2) begin err_cnt++; $display("FAIL single_data(j=%0d): got %h want b2", junk, bus.out_data); end
    @(posedge clk);
    #1;
    vec_cnt++; if (bus.out_valid !== 1'b0) begin err_cnt++; $display("FAIL single_valid_drop(j=%0d): got %b want 0", junk, bus.out_valid); end
    vec_cnt++; if (bus.fifo_count !== 3'd0) begin err_cnt++; $display("FAIL single_count(j=%0d): got %0d want 0", junk, bus.fifo_count); end
    repeat (3) @(posedge clk);
    #1;
    vec_cnt++; if (popped.size() != 1) begin err_cnt++; $display("FAIL single_pops(j=%0d): got %0d want 1", junk, popped.size()); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic [7:0] bytes [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    popped.delete();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) feed_byte(bytes[k], 1'b0, 1'b0);
    vec_cnt++; if (bus.fifo_count !== 3'd4) begin err_cnt++; $display("FAIL ovf_count: got %0d want 4", bus.fifo_count); end
    vec_cnt++; if (bus.overflow !== 1'b1) begin err_cnt++; $display("FAIL ovf_flag: got %b want 1", bus.overflow); end
    for (int k = 0; k < 3; k++) begin
      vec_cnt++; if (bus.out_data !== 8'h11) begin err_cnt++; $display("FAIL ovf_hold[%0d]: got %h want 11", k, bus.out_data); end
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    vec_cnt++; if (popped.size() != 4) begin err_cnt++; $display("FAIL ovf_pops: got %0d want 4", popped.size()); end
    for (int k = 0; k < 4 && k < popped.size(); k++) begin
      vec_cnt++; if (popped[k] !== bytes[k]) begin err_cnt++; $display("FAIL ovf_order[%0d]: got %h want %h", k, popped[k], bytes[k]); end
    end
    vec_cnt++; if (bus.overflow !== 1'b1) begin err_cnt++; $display("FAIL ovf_sticky: got %b want 1", bus.overflow); end
    pulse_clear();
    vec_cnt++; if (bus.overflow !== 1'b0) begin err_cnt++; $display("FAIL ovf_clear: got %b want 0", bus.overflow); end
  endtask

  task automatic test_push_with_pop();
    logic [7:0] bytes [5] = '{8'hA1, 8'hC2, 8'h93, 8'h64, 8'h35};
    popped.delete();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) feed_byte(bytes[k], 1'b0, 1'b0);
    feed_byte(bytes[4], 1'b0, 1'b1);
    vec_cnt++; if (bus.fifo_count !== 3'd4) begin err_cnt++; $display("FAIL pp_count: got %0d want 4", bus.fifo_count); end
    vec_cnt++; if (bus.overflow !== 1'b0) begin err_cnt++; $display("FAIL pp_ovf: got %b want 0", bus.overflow); end
    vec_cnt++; if (bus.out_data !== 8'hC2) begin err_cnt++; $display("FAIL pp_head: got %h want c2", bus.out_data); end
    bus.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    vec_cnt++; if (popped.size() != 5) begin err_cnt++; $display("FAIL pp_pops: got %0d want 5", popped.size()); end
    for (int k = 0; k < 5 && k < popped.size(); k++) begin
      vec_cnt++; if (popped[k] !== bytes[k]) begin err_cnt++; $display("FAIL pp_order[%0d]: got %h want %h", k, popped[k], bytes[k]); end
    end
  endtask

  task automatic test_reset_mid_byte();
    popped.delete();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) feed_pair(2'b10);
    rst = 1'b1;
    #3;
    vec_cnt++; if (bus.out_valid !== 1'b0) begin err_cnt++; $display("FAIL mid_rst_valid: got %b want 0", bus.out_valid); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    feed_byte(8'h3C, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    vec_cnt++; if (popped.size() != 1) begin err_cnt++; $display("FAIL mid_rst_pops: got %0d want 1", popped.size()); end
    if (popped.size() > 0) begin
      vec_cnt++; if (popped[0] !== 8'h3C) begin err_cnt++; $display("FAIL mid_rst_data: got %h want 3c", popped[0]); end
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_health();
    int exp_pops;
    exp_pops = HealthEn ? 0 : 1;
    pulse_clear();
    popped.delete();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 31; k++) feed_bit(1'b1);
    vec_cnt++; if (bus.health_fail !== 1'b0) begin err_cnt++; $display("FAIL rct_31: got %b want 0", bus.health_fail); end
    feed_bit(1'b1);
    vec_cnt++; if (bus.health_fail !== HealthEn) begin err_cnt++; $display("FAIL rct_32: got %b want %b", bus.health_fail, HealthEn); end
    feed_byte(8'h5A, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    vec_cnt++; if (popped.size() != exp_pops) begin err_cnt++; $display("FAIL rct_pops: got %0d want %0d", popped.size(), exp_pops); end
    if (popped.size() > 0) begin
      vec_cnt++; if (popped[0] !== 8'h5A) begin err_cnt++; $display("FAIL rct_data: got %h want 5a", popped[0]); end
    end
    vec_cnt++; if (bus.health_fail !== HealthEn) begin err_cnt++; $display("FAIL rct_sticky: got %b want %b", bus.health_fail, HealthEn); end
    pulse_clear();
    vec_cnt++; if (bus.health_fail !== 1'b0) begin err_cnt++; $display("FAIL rct_clear_hf: got %b want 0", bus.health_fail); end
    vec_cnt++; if (bus.fifo_count !== 3'd0) begin err_cnt++; $display("FAIL rct_clear_cnt: got %0d want 0", bus.fifo_count); end
    bus.out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_byte(1'b0);
    test_single_byte(1'b1);
    test_overflow();
    test_push_with_pop();
    test_reset_mid_byte();
    test_health();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
